// File: rtl/sp3_aligner_pkg.sv
// Shared definitions for the SP3 uplink frame aligner: FSM encoding and
// default tuning values for sync search, settling and loss-of-lock.
package sp3_aligner_pkg;

    localparam int FRAME_W = 234;

    localparam int DEF_PATTERN_LSB = 0;
    localparam int DEF_PATTERN_W   = 16;
    localparam int DEF_MATCH_N     = 8;
    localparam int DEF_SETTLE_N    = 64;
    localparam int DEF_MAX_SLIPS   = 64;
    localparam int DEF_UNLOCK_N    = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_CHECK    = 3'd2,
        ST_SLIP     = 3'd3,
        ST_SETTLE   = 3'd4,
        ST_LOCKED   = 3'd5,
        ST_FAIL     = 3'd6
    } aligner_state_t;

endpackage

// File: rtl/sp3_uplink_aligner.sv
// Frame aligner: hunts for the sync word by issuing bitslips to the dual-RX
// stage, declares lock after MATCH_N good frames and tracks errors once locked.
module sp3_uplink_aligner
    import sp3_aligner_pkg::*;
#(
    parameter int PATTERN_LSB = DEF_PATTERN_LSB,
    parameter int PATTERN_W   = DEF_PATTERN_W,
    parameter int MATCH_N     = DEF_MATCH_N,
    parameter int SETTLE_N    = DEF_SETTLE_N,
    parameter int MAX_SLIPS   = DEF_MAX_SLIPS,
    parameter int UNLOCK_N    = DEF_UNLOCK_N
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    input  logic                 enable_i,
    input  logic                 uplinkrdy_i,
    input  logic                 frame_valid_i,
    input  logic [FRAME_W-1:0]   uplinkUserData_i,
    input  logic [PATTERN_W-1:0] sync_pattern_i,
    output logic                 pulse_bitslip_o,
    output logic                 locked_o,
    output logic                 fail_o,
    output logic [7:0]           slip_count_o,
    output logic [15:0]          err_count_o,
    output logic [2:0]           state_o
);

    localparam int MATCH_CW  = $clog2(MATCH_N + 1);
    localparam int SETTLE_CW = $clog2(SETTLE_N + 1);
    localparam int MISS_CW   = $clog2(UNLOCK_N + 1);
    localparam logic [7:0] SLIP_LIMIT = 8'(MAX_SLIPS);
    localparam logic [FRAME_W-1:0] FIELD_MASK =
        ((FRAME_W'(1) << PATTERN_W) - FRAME_W'(1)) << PATTERN_LSB;

    aligner_state_t        state, state_next;
    logic [MATCH_CW-1:0]   match_cnt, match_next;
    logic [SETTLE_CW-1:0]  settle_cnt, settle_next;
    logic [MISS_CW-1:0]    miss_cnt, miss_next;
    logic [7:0]            slip_next;
    logic [15:0]           err_next;
    logic                  accepted, is_match, pulse_next;

    assign accepted = frame_valid_i & uplinkrdy_i;
    // Compare on the whole frame through a mask so every data bit is consumed.
    assign is_match = (uplinkUserData_i & FIELD_MASK) ==
                      (FRAME_W'(sync_pattern_i) << PATTERN_LSB);
    assign state_o  = state;

    always_comb begin
        state_next  = state;
        match_next  = match_cnt;
        settle_next = settle_cnt;
        miss_next   = miss_cnt;
        slip_next   = slip_count_o;
        err_next    = err_count_o;

        // The pulse has already gone out during a SLIP cycle, so count it even if we leave early.
        if (state == ST_SLIP && slip_count_o < SLIP_LIMIT)
            slip_next = slip_count_o + 8'd1;

        if (!enable_i) begin
            state_next = ST_IDLE;
        end else if (!uplinkrdy_i && (state == ST_CHECK || state == ST_SLIP ||
                                      state == ST_SETTLE || state == ST_LOCKED)) begin
            state_next = ST_WAIT_RDY;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    slip_next  = '0;
                    err_next   = '0;
                    state_next = ST_WAIT_RDY;
                end
                ST_WAIT_RDY: begin
                    if (uplinkrdy_i) begin
                        match_next = '0;
                        state_next = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (accepted) begin
                        if (!is_match) begin
                            state_next = ST_SLIP;
                        end else if (match_cnt == MATCH_CW'(MATCH_N - 1)) begin
                            miss_next  = '0;
                            state_next = ST_LOCKED;
                        end else begin
                            match_next = match_cnt + 1'b1;
                        end
                    end
                end
                ST_SLIP: begin
                    settle_next = '0;
                    state_next  = (slip_count_o < SLIP_LIMIT) ? ST_SETTLE : ST_FAIL;
                end
                ST_SETTLE: begin
                    if (accepted) begin
                        if (settle_cnt == SETTLE_CW'(SETTLE_N - 1)) begin
                            settle_next = '0;
                            match_next  = '0;
                            state_next  = ST_CHECK;
                        end else begin
                            settle_next = settle_cnt + 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (accepted) begin
                        if (is_match) begin
                            miss_next = '0;
                        end else begin
                            if (err_count_o != 16'hFFFF)
                                err_next = err_count_o + 16'd1;
                            if (miss_cnt == MISS_CW'(UNLOCK_N - 1)) begin
                                miss_next  = '0;
                                match_next = '0;
                                state_next = ST_CHECK;
                            end else begin
                                miss_next = miss_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_FAIL: state_next = ST_FAIL;
                default: state_next = ST_IDLE;
            endcase
        end

        pulse_next = (state_next == ST_SLIP) && (slip_count_o < SLIP_LIMIT);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state           <= ST_IDLE;
            match_cnt       <= '0;
            settle_cnt      <= '0;
            miss_cnt        <= '0;
            slip_count_o    <= '0;
            err_count_o     <= '0;
            pulse_bitslip_o <= 1'b0;
            locked_o        <= 1'b0;
            fail_o          <= 1'b0;
        end else begin
            state           <= state_next;
            match_cnt       <= match_next;
            settle_cnt      <= settle_next;
            miss_cnt        <= miss_next;
            slip_count_o    <= slip_next;
            err_count_o     <= err_next;
            pulse_bitslip_o <= pulse_next;
            locked_o        <= (state_next == ST_LOCKED);
            fail_o          <= (state_next == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_sp3_uplink_aligner.sv
// Scoreboard bench: stimulus queues expected state changes, error-count changes
// and bitslip pulses; a monitor pops and compares them as the DUT produces them.
module tb_sp3_uplink_aligner;
    import sp3_aligner_pkg::*;

    localparam logic [15:0]  PAT  = 16'hA5C3;
    localparam logic [15:0]  BAD  = 16'h5A3C;
    localparam logic [217:0] FILL = 218'h2_468A_CE13_579B_DEAD_BEEF;

    typedef struct packed {
        logic [2:0]  st;
        logic        lk;
        logic        fl;
        logic [7:0]  sc;
        logic [15:0] ec;
    } snap_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         enable = 1'b0;
    logic         rdy = 1'b0;
    logic         fvalid = 1'b0;
    logic [233:0] data = '0;
    logic [15:0]  sync = PAT;
    logic         sel = 1'b0;
    logic         done = 1'b0;

    logic        p0, l0, f0, p5, l5, f5;
    logic [7:0]  sc0, sc5;
    logic [15:0] ec0, ec5;
    logic [2:0]  st0, st5;

    logic        v_p, v_lk, v_fl;
    logic [7:0]  v_sc;
    logic [15:0] v_ec;
    logic [2:0]  v_st;

    snap_t       exp_state_q[$];
    logic [15:0] exp_err_q[$];
    logic [7:0]  exp_pulse_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sp3_uplink_aligner dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .enable_i(enable),
        .uplinkrdy_i(rdy), .frame_valid_i(fvalid), .uplinkUserData_i(data),
        .sync_pattern_i(sync), .pulse_bitslip_o(p0), .locked_o(l0),
        .fail_o(f0), .slip_count_o(sc0), .err_count_o(ec0), .state_o(st0)
    );

    // Second instance with a small slip budget for the exhaustion scenario.
    sp3_uplink_aligner #(.MAX_SLIPS(5)) dut5 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .enable_i(enable),
        .uplinkrdy_i(rdy), .frame_valid_i(fvalid), .uplinkUserData_i(data),
        .sync_pattern_i(sync), .pulse_bitslip_o(p5), .locked_o(l5),
        .fail_o(f5), .slip_count_o(sc5), .err_count_o(ec5), .state_o(st5)
    );

    assign v_p  = sel ? p5  : p0;
    assign v_lk = sel ? l5  : l0;
    assign v_fl = sel ? f5  : f0;
    assign v_sc = sel ? sc5 : sc0;
    assign v_ec = sel ? ec5 : ec0;
    assign v_st = sel ? st5 : st0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic good);
        fvalid = 1'b1;
        data   = {FILL, good ? PAT : BAD};
        tick();
        fvalid = 1'b0;
        tick();
    endtask

    task automatic pushState(input logic [2:0] st, input logic lk, input logic fl,
                             input logic [7:0] sc, input logic [15:0] ec);
        exp_state_q.push_back({st, lk, fl, sc, ec});
    endtask

    // Monitor: the only process that counts comparisons.
    logic [2:0]  prev_st = 3'd0;
    logic [15:0] prev_ec = 16'd0;
    logic        prev_p  = 1'b0;

    always @(negedge clk or negedge rst_n) begin
        snap_t act;
        snap_t exp_s;
        logic [15:0] exp_e;
        logic [7:0]  exp_p;
        #1;
        act = {v_st, v_lk, v_fl, v_sc, v_ec};
        if (!rst_n)
            checkOutput("reset_zero", {2'b0, act, v_p}, 32'd0);
        if (v_st != prev_st) begin
            if (exp_state_q.size() == 0) begin
                checkOutput("unexpected_state_change", {29'd0, v_st}, {29'd0, prev_st});
            end else begin
                exp_s = exp_state_q.pop_front();
                checkOutput("state_snapshot", {3'd0, act}, {3'd0, exp_s});
            end
        end
        if (v_ec != prev_ec) begin
            if (exp_err_q.size() == 0) begin
                checkOutput("unexpected_err_change", {16'd0, v_ec}, {16'd0, prev_ec});
            end else begin
                exp_e = exp_err_q.pop_front();
                checkOutput("err_count", {16'd0, v_ec}, {16'd0, exp_e});
            end
        end
        if (v_p) begin
            if (exp_pulse_q.size() == 0) begin
                checkOutput("unexpected_pulse", {24'd0, v_sc}, 32'hFFFF_FFFF);
            end else begin
                exp_p = exp_pulse_q.pop_front();
                checkOutput("pulse_slip_count", {23'd0, prev_p, v_sc}, {24'd0, exp_p});
            end
        end
        prev_st = v_st;
        prev_ec = v_ec;
        prev_p  = v_p;
        if (done && rst_n && !clk) begin
            checkOutput("state_q_drained", exp_state_q.size(), 32'd0);
            checkOutput("err_q_drained", exp_err_q.size(), 32'd0);
            checkOutput("pulse_q_drained", exp_pulse_q.size(), 32'd0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pattern present from the first frame: lock on the 8th accepted frame.
        pushState(3'd1, 0, 0, 8'd0, 16'd0);
        enable = 1'b1;
        tick();
        pushState(3'd2, 0, 0, 8'd0, 16'd0);
        rdy = 1'b1;
        tick();
        repeat (7) applyStimulus(1'b1);
        pushState(3'd5, 1, 0, 8'd0, 16'd0);
        applyStimulus(1'b1);

        // Locked: 3 misses then a match keeps lock; 4 consecutive misses drop it.
        for (int k = 1; k <= 3; k++) begin
            exp_err_q.push_back(16'(k));
            applyStimulus(1'b0);
        end
        applyStimulus(1'b1);
        for (int k = 4; k <= 7; k++) exp_err_q.push_back(16'(k));
        pushState(3'd2, 0, 0, 8'd0, 16'd7);
        repeat (4) applyStimulus(1'b0);

        // Restart, then three failed attempts before the pattern appears.
        pushState(3'd0, 0, 0, 8'd0, 16'd7);
        enable = 1'b0;
        tick();
        exp_err_q.push_back(16'd0);
        pushState(3'd1, 0, 0, 8'd0, 16'd0);
        pushState(3'd2, 0, 0, 8'd0, 16'd0);
        enable = 1'b1;
        tick();
        tick();
        for (int a = 0; a < 3; a++) begin
            pushState(3'd3, 0, 0, 8'(a), 16'd0);
            exp_pulse_q.push_back(8'(a));
            pushState(3'd4, 0, 0, 8'(a + 1), 16'd0);
            pushState(3'd2, 0, 0, 8'(a + 1), 16'd0);
            repeat (65) applyStimulus(1'b0);
        end
        pushState(3'd5, 1, 0, 8'd3, 16'd0);
        repeat (8) applyStimulus(1'b1);

        // Drop lock, slip once more, then lose uplink ready mid-settle.
        for (int k = 1; k <= 4; k++) exp_err_q.push_back(16'(k));
        pushState(3'd2, 0, 0, 8'd3, 16'd4);
        repeat (4) applyStimulus(1'b0);
        pushState(3'd3, 0, 0, 8'd3, 16'd4);
        exp_pulse_q.push_back(8'd3);
        pushState(3'd4, 0, 0, 8'd4, 16'd4);
        repeat (6) applyStimulus(1'b0);
        pushState(3'd1, 0, 0, 8'd4, 16'd4);
        rdy = 1'b0;
        repeat (4) tick();
        pushState(3'd2, 0, 0, 8'd4, 16'd4);
        rdy = 1'b1;
        tick();

        // Asynchronous reset in the middle of a CHECK run.
        repeat (3) applyStimulus(1'b1);
        pushState(3'd0, 0, 0, 8'd0, 16'd0);
        exp_err_q.push_back(16'd0);
        #2;
        rst_n  = 1'b0;
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Slip budget of 5 exhausted: fail, then an enable toggle restarts.
        sel = 1'b1;
        pushState(3'd1, 0, 0, 8'd0, 16'd0);
        pushState(3'd2, 0, 0, 8'd0, 16'd0);
        enable = 1'b1;
        tick();
        tick();
        for (int a = 0; a < 5; a++) begin
            pushState(3'd3, 0, 0, 8'(a), 16'd0);
            exp_pulse_q.push_back(8'(a));
            pushState(3'd4, 0, 0, 8'(a + 1), 16'd0);
            pushState(3'd2, 0, 0, 8'(a + 1), 16'd0);
            repeat (65) applyStimulus(1'b0);
        end
        pushState(3'd3, 0, 0, 8'd5, 16'd0);
        pushState(3'd6, 0, 1, 8'd5, 16'd0);
        applyStimulus(1'b0);
        repeat (5) tick();
        pushState(3'd0, 0, 0, 8'd5, 16'd0);
        enable = 1'b0;
        tick();
        pushState(3'd1, 0, 0, 8'd0, 16'd0);
        pushState(3'd2, 0, 0, 8'd0, 16'd0);
        enable = 1'b1;
        repeat (6) tick();
        done = 1'b1;
    end

endmodule
